adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 115 +++++++++++
 tb/tb_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder -- registered WIDTH-bit adder built from 4-bit carry-lookahead groups
//
// Computes {cout, sum} = i_a + i_b + i_cin exactly over WIDTH+1 bits.
// To subtract, drive i_b with the inverted subtrahend and set i_cin = 1.
// Each 4-bit group resolves its internal carries by lookahead from per-bit
// generate/propagate terms. The group carry-out then ripples into the next
// group. WIDTH must be a multiple of 4 and at least 4.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   i_a, i_b   : operands (unsigned or two's complement)
//   i_cin      : carry-in
//   i_valid    : operands valid this cycle
//   o_result   : registered sum (low WIDTH bits); holds when i_valid = 0
//   o_cout     : registered carry-out of the MSB
//   o_overflow : registered signed overflow
//   o_zero     : registered flag, 1 when o_result == 0
//   o_valid    : registered copy of i_valid (one pulse per accepted op)
// ---------------------------------------------------------------------------
module adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_valid
);

  localparam int GROUPS = WIDTH / 4;

  // One 4-bit carry-lookahead group. Returns {group carry-out, sum[3:0]}.
  // The carry-out is formed from the group generate/propagate terms, so
  // the chain between groups is one G/P stage per group.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pg;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    pg   = &p;
    return {gg | (pg & cin), p ^ c};
  endfunction

  // ---- stage p0: combinational sum and flags from the input operands ----
  logic [GROUPS:0]  carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;
  logic             zero_p0;

  assign carry_p0[0] = i_cin;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
    assign {carry_p0[gi+1], sum_p0[4*gi +: 4]} =
      cla4(i_a[4*gi +: 4], i_b[4*gi +: 4], carry_p0[gi]);
  end

  // Same-sign operands whose sum changes sign have overflowed.
  assign ovf_p0  = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                   (sum_p0[WIDTH-1] != i_a[WIDTH-1]);
  assign zero_p0 = (sum_p0 == '0);

  // ---- stage p1: output registers ----
  logic [WIDTH-1:0] result_p1;
  logic             cout_p1;
  logic             ovf_p1;
  logic             zero_p1;
  logic             vld_p1;

  // Result and flags are cleared by reset as well, so the outputs read as
  // zero while reset is held. An op sampled during reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_p1 <= '0;
      cout_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
      zero_p1   <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= i_valid;
      if (i_valid) begin
        result_p1 <= sum_p0;
        cout_p1   <= carry_p0[GROUPS];
        ovf_p1    <= ovf_p0;
        zero_p1   <= zero_p0;
      end
    end
  end

  assign o_result   = result_p1;
  assign o_cout     = cout_p1;
  assign o_overflow = ovf_p1;
  assign o_zero     = zero_p1;
  assign o_valid    = vld_p1;

endmodule

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder -- self-checking bench for adder (WIDTH = 32)
//
// Expected results come from a behavioural reference sum. The bench pushes
// each expected value into a queue when it drives the operands. It pops the
// value and compares it one cycle later, #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         i_valid;
  logic [W-1:0] o_result;
  logic         o_cout;
  logic         o_overflow;
  logic         o_zero;
  logic         o_valid;

  adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_cin      (i_cin),
    .i_valid    (i_valid),
    .o_result   (o_result),
    .o_cout     (o_cout),
    .o_overflow (o_overflow),
    .o_zero     (o_zero),
    .o_valid    (o_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t       sbq[$];
  exp_t       last;
  exp_t       e;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W+3:0] obs;

  assign obs = {o_result, o_cout, o_overflow, o_zero, o_valid};

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    logic [W:0] s;
    exp_t       m;
    s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    m.r = s[W-1:0];
    m.c = s[W];
    m.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    m.z = (s[W-1:0] == '0);
    return m;
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic vld);
    @(negedge clk);
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_valid = vld;
    if (vld) sbq.push_back(model(a, b, cin));
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    i_a     = 32'h1234_5678;
    i_b     = 32'h1111_1111;
    i_cin   = 1'b0;
    i_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, {(W+4){1'b0}});
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_held_valid_ignored: got %h want %h", obs, {(W+4){1'b0}});
    end
    @(negedge clk);
    i_valid = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'h0000_0005, 32'h8000_0000, 32'h0F0F_0F0F};
    logic [W-1:0] vb [6] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0001,
                             32'hFFFF_FFFC, 32'h8000_0000, 32'hF0F0_F0F0};
    logic         vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      @(posedge clk);
      #1;
      e    = sbq.pop_front();
      last = e;
      n_checks++;
      if (obs !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL vector_%0d: got %h want %h", i, obs, {e, 1'b1});
      end
    end
    drive(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {last, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_after_vectors: got %h want %h", obs, {last, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    drive(32'd1, 32'd1, 1'b0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      if (i <= 3) drive(i, i, 1'b0, 1'b1);
      else        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
      #1;
      e    = sbq.pop_front();
      last = e;
      n_checks++;
      if (obs !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h want %h", i - 1, obs, {e, 1'b1});
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {W'(6), 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_hold: got %h want %h", obs, {W'(6), 4'b0000});
    end
  endtask

  task automatic test_midcycle();
    drive(32'd9, 32'd9, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    e    = sbq.pop_front();
    last = e;
    n_checks++;
    if (obs !== {e, 1'b1}) begin
      n_fail++;
      $display("FAIL midcycle_load: got %h want %h", obs, {e, 1'b1});
    end
    i_a   = 32'hFFFF_0000;
    i_b   = 32'h0001_FFFF;
    i_cin = 1'b1;
    #3;
    n_checks++;
    if (obs !== {e, 1'b1}) begin
      n_fail++;
      $display("FAIL midcycle_stable: got %h want %h", obs, {e, 1'b1});
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    drive(32'h10, 32'h20, 1'b0, 1'b1);
    sbq.delete();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL inflight_async_clear: got %h want %h", obs, {(W+4){1'b0}});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL inflight_no_valid: got %h want %h", obs, {(W+4){1'b0}});
    end
    @(negedge clk);
    reset   = 1'b1;
    i_valid = 1'b0;
    drive(32'd7, 32'd8, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    e    = sbq.pop_front();
    last = e;
    n_checks++;
    if (obs !== {W'(15), 4'b0001}) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h want %h", obs, {W'(15), 4'b0001});
    end
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {last, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_pulse: got %h want %h", obs, {last, 1'b0});
    end
  endtask

  task automatic test_random();
    logic vld;
    for (int i = 0; i < 60; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), vld);
      @(posedge clk);
      #1;
      n_checks++;
      if (vld) begin
        e    = sbq.pop_front();
        last = e;
        if (obs !== {e, 1'b1}) begin
          n_fail++;
          $display("FAIL random_%0d: got %h want %h", i, obs, {e, 1'b1});
        end
      end else if (obs !== {last, 1'b0}) begin
        n_fail++;
        $display("FAIL random_hold_%0d: got %h want %h", i, obs, {last, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_midcycle();
    test_reset_inflight();
    test_random();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
